tnoc_axi_write_read_demux: RTL and testbench

Receive-side counterpart of the AXI adapter's write/read merge. It takes the multi-VC flit stream arriving from the router's local port and splits it into two single-channel streams: a write stream (WRITE, POSTED_WRITE, RESPONSE packets) and a read stream (READ, RESPONSE_WITH_DATA packets). Each output has its own packet-locked round-robin VC arbiter and a one-entry output register. The source VC of every delivered flit is reported alongside it.

---
 rtl/tnoc_axi_write_read_demux_if.sv | 42 ++++
 rtl/tnoc_axi_write_read_demux.sv | 186 ++++++++++++++++++
 tb/tb_tnoc_axi_write_read_demux.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnoc_axi_write_read_demux_if.sv
// Shared NoC configuration, packet types and the multi-VC flit handshake interface.
// Header fields sit in the low bits of a flit: head, tail, packet_type, then payload.
package tnoc_pkg;
  typedef struct packed {
    int virtual_channels;
    int data_width;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2, data_width: 16};

  typedef enum logic [2:0] {
    TNOC_WRITE              = 3'd0,
    TNOC_POSTED_WRITE       = 3'd1,
    TNOC_READ               = 3'd2,
    TNOC_RESPONSE           = 3'd3,
    TNOC_RESPONSE_WITH_DATA = 3'd4
  } tnoc_packet_type;

  localparam int FLIT_HEAD_BIT  = 0;
  localparam int FLIT_TAIL_BIT  = 1;
  localparam int FLIT_TYPE_LSB  = 2;
  localparam int FLIT_HDR_BITS  = 5;

  function automatic int tnoc_flit_width(tnoc_config cfg);
    return cfg.data_width + FLIT_HDR_BITS;
  endfunction
endpackage

interface tnoc_flit_if #(
  parameter tnoc_pkg::tnoc_config CONFIG   = tnoc_pkg::TNOC_DEFAULT_CONFIG,
  parameter int                   CHANNELS = CONFIG.virtual_channels
);
  localparam int FLIT_WIDTH = tnoc_pkg::tnoc_flit_width(CONFIG);

  logic [CHANNELS-1:0]                 valid;
  logic [CHANNELS-1:0]                 ready;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] flit;
  logic [CHANNELS-1:0]                 vc_available;

  modport initiator (output valid, input ready, output flit, input vc_available);
  modport target    (input valid, output ready, input flit, output vc_available);
endinterface

// File: rtl/tnoc_axi_write_read_demux.sv
// Splits the router's multi-VC receive stream into a write-class and a read-class
// single-channel stream, each with a packet-locked round-robin arbiter and output register.
module tnoc_axi_write_read_demux #(
  parameter tnoc_pkg::tnoc_config CONFIG   = tnoc_pkg::TNOC_DEFAULT_CONFIG,
  parameter int                   WRITE_VC = -1,
  parameter int                   READ_VC  = -1,
  localparam int                  CHANNELS = CONFIG.virtual_channels,
  localparam int                  VC_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
  input  logic                clk,
  input  logic                rst_n,
  tnoc_flit_if.target         flit_in_if,
  tnoc_flit_if.initiator      write_flit_if,
  output logic [VC_WIDTH-1:0] o_write_vc,
  tnoc_flit_if.initiator      read_flit_if,
  output logic [VC_WIDTH-1:0] o_read_vc
);
  import tnoc_pkg::*;

  localparam int FLIT_WIDTH = tnoc_flit_width(CONFIG);
  localparam int PORTS      = 2;
  localparam int WR         = 0;
  localparam int RD         = 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} port_state_e;

  port_state_e               state_r    [PORTS];
  port_state_e               state_s    [PORTS];
  logic [VC_WIDTH-1:0]       lock_vc_r  [PORTS];
  logic [VC_WIDTH-1:0]       lock_vc_s  [PORTS];
  logic [VC_WIDTH-1:0]       rr_ptr_r   [PORTS];
  logic [VC_WIDTH-1:0]       rr_ptr_s   [PORTS];
  logic [PORTS-1:0]          out_valid_r;
  logic [PORTS-1:0]          out_valid_s;
  logic [FLIT_WIDTH-1:0]     out_flit_r [PORTS];
  logic [FLIT_WIDTH-1:0]     out_flit_s [PORTS];
  logic [VC_WIDTH-1:0]       out_vc_r   [PORTS];
  logic [VC_WIDTH-1:0]       out_vc_s   [PORTS];

  logic [CHANNELS-1:0]       cand_s     [PORTS];
  logic [PORTS-1:0]          grant_s;
  logic [VC_WIDTH-1:0]       owner_s    [PORTS];
  logic [PORTS-1:0]          out_ready_s;
  logic [PORTS-1:0]          can_load_s;
  logic [PORTS-1:0]          accept_s;
  logic [CHANNELS-1:0]       ready_s;

  function automatic logic is_read_class(logic [FLIT_WIDTH-1:0] f);
    logic [2:0] t;
    t = f[FLIT_TYPE_LSB +: 3];
    return (t == TNOC_READ) || (t == TNOC_RESPONSE_WITH_DATA);
  endfunction

  function automatic logic vc_permitted(int p, int v);
    int limit;
    limit = (p == WR) ? WRITE_VC : READ_VC;
    return (limit < 0) || (limit == v);
  endfunction

  function automatic logic [VC_WIDTH-1:0] rr_index(logic [VC_WIDTH-1:0] ptr, int step);
    int idx;
    idx = (int'(ptr) + step) % CHANNELS;
    return idx[VC_WIDTH-1:0];
  endfunction

  assign out_ready_s = {read_flit_if.ready[0], write_flit_if.ready[0]};
  assign can_load_s  = ~out_valid_r | out_ready_s;

  // Header candidates per port: class match, not owned by the other port, VC permitted.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      for (int v = 0; v < CHANNELS; v++) begin
        cand_s[p][v] = flit_in_if.valid[v] && flit_in_if.flit[v][FLIT_HEAD_BIT] &&
                       (is_read_class(flit_in_if.flit[v]) == (p == RD)) &&
                       !((state_r[1-p] == LOCKED) && (lock_vc_r[1-p] == VC_WIDTH'(v))) &&
                       vc_permitted(p, v);
      end
    end
  end

  // Owner selection: the locked VC, or the first candidate after the last grant.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      grant_s[p] = 1'b0;
      owner_s[p] = '0;
      if (state_r[p] == LOCKED) begin
        grant_s[p] = 1'b1;
        owner_s[p] = lock_vc_r[p];
      end else begin
        for (int k = 1; k <= CHANNELS; k++) begin
          owner_s[p] = (!grant_s[p] && cand_s[p][rr_index(rr_ptr_r[p], k)]) ?
                       rr_index(rr_ptr_r[p], k) : owner_s[p];
          grant_s[p] = grant_s[p] | cand_s[p][rr_index(rr_ptr_r[p], k)];
        end
      end
      accept_s[p] = grant_s[p] && can_load_s[p] && flit_in_if.valid[owner_s[p]];
    end
  end

  // Input ready follows the owning port's load enable; held low while in reset.
  always_comb begin
    ready_s = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int v = 0; v < CHANNELS; v++) begin
        ready_s[v] = ready_s[v] | (grant_s[p] && can_load_s[p] && (owner_s[p] == VC_WIDTH'(v)));
      end
    end
  end

  assign flit_in_if.ready        = ready_s & {CHANNELS{rst_n}};
  assign flit_in_if.vc_available = '1;

  // Per-port lock FSM, round-robin pointer and output register next state.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      state_s[p]     = state_r[p];
      lock_vc_s[p]   = lock_vc_r[p];
      rr_ptr_s[p]    = rr_ptr_r[p];
      out_valid_s[p] = out_valid_r[p];
      out_flit_s[p]  = out_flit_r[p];
      out_vc_s[p]    = out_vc_r[p];
      case (state_r[p])
        IDLE: begin
          if (accept_s[p]) begin
            rr_ptr_s[p] = owner_s[p];
            if (!flit_in_if.flit[owner_s[p]][FLIT_TAIL_BIT]) begin
              state_s[p]   = LOCKED;
              lock_vc_s[p] = owner_s[p];
            end else begin
              state_s[p] = IDLE;
            end
          end else begin
            state_s[p] = IDLE;
          end
        end
        LOCKED: begin
          if (accept_s[p] && flit_in_if.flit[owner_s[p]][FLIT_TAIL_BIT]) begin
            state_s[p] = IDLE;
          end else begin
            state_s[p] = LOCKED;
          end
        end
        default: state_s[p] = IDLE;
      endcase
      if (accept_s[p]) begin
        out_valid_s[p] = 1'b1;
        out_flit_s[p]  = flit_in_if.flit[owner_s[p]];
        out_vc_s[p]    = owner_s[p];
      end else if (out_ready_s[p]) begin
        out_valid_s[p] = 1'b0;
      end else begin
        out_valid_s[p] = out_valid_r[p];
      end
    end
  end

  // State and output registers; pointers start at the last VC so VC0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= '0;
      for (int p = 0; p < PORTS; p++) begin
        state_r[p]    <= IDLE;
        lock_vc_r[p]  <= '0;
        rr_ptr_r[p]   <= VC_WIDTH'(CHANNELS - 1);
        out_flit_r[p] <= '0;
        out_vc_r[p]   <= '0;
      end
    end else begin
      out_valid_r <= out_valid_s;
      for (int p = 0; p < PORTS; p++) begin
        state_r[p]    <= state_s[p];
        lock_vc_r[p]  <= lock_vc_s[p];
        rr_ptr_r[p]   <= rr_ptr_s[p];
        out_flit_r[p] <= out_flit_s[p];
        out_vc_r[p]   <= out_vc_s[p];
      end
    end
  end

  assign write_flit_if.valid   = out_valid_r[WR];
  assign write_flit_if.flit[0] = out_flit_r[WR];
  assign o_write_vc            = out_vc_r[WR];
  assign read_flit_if.valid    = out_valid_r[RD];
  assign read_flit_if.flit[0]  = out_flit_r[RD];
  assign o_read_vc             = out_vc_r[RD];
endmodule

// File: tb/tb_tnoc_axi_write_read_demux.sv
// Directed bench for tnoc_axi_write_read_demux: per-VC source queues feed a
// packet-level reference of both ports, compared against the DUT every cycle.
module tb_tnoc_axi_write_read_demux;
  import tnoc_pkg::*;

  localparam tnoc_config CFG = TNOC_DEFAULT_CONFIG;
  localparam int CH  = CFG.virtual_channels;
  localparam int FW  = tnoc_flit_width(CFG);
  localparam int LIM_WR = -1;
  localparam int LIM_RD = -1;

  typedef struct {
    int          vc;
    logic [15:0] data;
    int          cyc;
  } log_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tnoc_flit_if #(.CONFIG(CFG), .CHANNELS(CH)) in_if ();
  tnoc_flit_if #(.CONFIG(CFG), .CHANNELS(1))  wr_if ();
  tnoc_flit_if #(.CONFIG(CFG), .CHANNELS(1))  rd_if ();
  logic [0:0] write_vc;
  logic [0:0] read_vc;

  assign wr_if.vc_available = 1'b1;
  assign rd_if.vc_available = 1'b1;

  tnoc_axi_write_read_demux #(.CONFIG(CFG), .WRITE_VC(LIM_WR), .READ_VC(LIM_RD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flit_in_if    (in_if),
    .write_flit_if (wr_if),
    .o_write_vc    (write_vc),
    .read_flit_if  (rd_if),
    .o_read_vc     (read_vc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [FW-1:0] src_q [CH][$];
  log_t          wr_log[$];
  log_t          rd_log[$];

  bit            m_locked [2];
  int            m_lvc    [2];
  int            m_last   [2];
  bit            m_oval   [2];
  logic [FW-1:0] m_oflit  [2];
  int            m_ovc    [2];

  function automatic logic [FW-1:0] mk(bit h, bit t, tnoc_packet_type ty, logic [15:0] d);
    return {d, ty, t, h};
  endfunction

  function automatic bit is_rd(logic [FW-1:0] f);
    return (f[4:2] == TNOC_READ) || (f[4:2] == TNOC_RESPONSE_WITH_DATA);
  endfunction

  function automatic bit permitted(int p, int v);
    int lim;
    lim = (p == 0) ? LIM_WR : LIM_RD;
    return (lim < 0) || (lim == v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_locked[p] = 1'b0;
      m_lvc[p]    = 0;
      m_last[p]   = CH - 1;
      m_oval[p]   = 1'b0;
      m_oflit[p]  = '0;
      m_ovc[p]    = 0;
    end
  endtask

  // Drive inputs from the source queues, compare against the reference, then advance it.
  initial begin : cmp
    logic [CH-1:0] vin;
    logic [FW-1:0] fin [CH];
    logic [CH-1:0] exp_ready;
    bit            acc  [2];
    int            avc  [2];
    bit            ordy [2];
    int            own;
    bit            can;
    logic [FW-1:0] f;
    model_reset();
    forever begin
      @(negedge clk);
      for (int v = 0; v < CH; v++) begin
        vin[v] = rst_n && (src_q[v].size() > 0);
        fin[v] = (src_q[v].size() > 0) ? src_q[v][0] : '0;
        in_if.valid[v] = vin[v];
        in_if.flit[v]  = fin[v];
      end
      #1;
      cyc++;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      if (!rst_n) begin
        model_reset();
        chk("rst_wr_valid", wr_if.valid, 0);
        chk("rst_wr_flit", wr_if.flit[0], 0);
        chk("rst_wr_vc", write_vc, 0);
        chk("rst_rd_valid", rd_if.valid, 0);
        chk("rst_rd_flit", rd_if.flit[0], 0);
        chk("rst_rd_vc", read_vc, 0);
        chk("rst_in_ready", in_if.ready, 0);
      end else begin
        for (int v = 0; v < CH; v++) begin
          assert (!(vin[v] && !fin[v][0] &&
                    !((m_locked[0] && m_lvc[0] == v) || (m_locked[1] && m_lvc[1] == v))))
            else $error("protocol error: non-header flit on unowned VC %0d", v);
        end
        ordy[0] = wr_if.ready[0];
        ordy[1] = rd_if.ready[0];
        chk("wr_valid", wr_if.valid, m_oval[0]);
        if (m_oval[0]) begin
          chk("wr_flit", wr_if.flit[0], m_oflit[0]);
          chk("wr_vc", write_vc, m_ovc[0]);
        end
        chk("rd_valid", rd_if.valid, m_oval[1]);
        if (m_oval[1]) begin
          chk("rd_flit", rd_if.flit[0], m_oflit[1]);
          chk("rd_vc", read_vc, m_ovc[1]);
        end
        if (wr_if.valid[0] && ordy[0]) wr_log.push_back('{int'(write_vc), wr_if.flit[0][FW-1:5], cyc});
        if (rd_if.valid[0] && ordy[1]) rd_log.push_back('{int'(read_vc), rd_if.flit[0][FW-1:5], cyc});
        exp_ready = '0;
        for (int p = 0; p < 2; p++) begin
          own = -1;
          if (m_locked[p]) begin
            own = m_lvc[p];
          end else begin
            for (int k = 1; k <= CH; k++) begin
              int v;
              v = (m_last[p] + k) % CH;
              if (own < 0 && vin[v] && fin[v][0] && (int'(is_rd(fin[v])) == p) &&
                  !(m_locked[1-p] && m_lvc[1-p] == v) && permitted(p, v))
                own = v;
            end
          end
          can = !m_oval[p] || ordy[p];
          if (own >= 0 && can) begin
            exp_ready[own] = 1'b1;
            acc[p] = vin[own];
            avc[p] = own;
          end
        end
        chk("in_ready", in_if.ready, exp_ready);
      end
      @(posedge clk);
      if (rst_n) begin
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) begin
            f = fin[avc[p]];
            void'(src_q[avc[p]].pop_front());
            if (!m_locked[p]) begin
              m_last[p] = avc[p];
              if (!f[1]) begin
                m_locked[p] = 1'b1;
                m_lvc[p]    = avc[p];
              end
            end else if (f[1]) begin
              m_locked[p] = 1'b0;
            end
            m_oval[p]  = 1'b1;
            m_oflit[p] = f;
            m_ovc[p]   = avc[p];
          end else if (ordy[p]) begin
            m_oval[p] = 1'b0;
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int v = 0; v < CH; v++) src_q[v].delete();
    step(2);
    rst_n = 1'b1;
    wr_log.delete();
    rd_log.delete();
  endtask

  task automatic wait_drain(string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && !m_oval[0] && !m_oval[1];
    end
    chk(name, done, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  // Directed scenarios with literal expectations on the delivered streams.
  initial begin : stim
    logic [15:0] held_data;
    rst_n = 1'b0;
    wr_if.ready = 1'b1;
    rd_if.ready = 1'b1;
    in_if.valid = '0;
    in_if.flit  = '0;
    step(3);
    chk("reset_in_ready", in_if.ready, 0);
    chk("reset_vc_avail", in_if.vc_available, 2'b11);
    rst_n = 1'b1;

    // Single-flit write on VC1: one-cycle latency, read side untouched.
    src_q[1].push_back(mk(1, 1, TNOC_WRITE, 16'hA001));
    step(1);
    chk("t1_wr_valid", wr_if.valid, 1);
    chk("t1_wr_vc", write_vc, 1);
    chk("t1_wr_data", wr_if.flit[0][FW-1:5], 16'hA001);
    chk("t1_rd_valid", rd_if.valid, 0);
    wait_drain("t1_drain");
    chk("t1_wr_count", wr_log.size(), 1);
    chk("t1_rd_count", rd_log.size(), 0);

    // 4-flit READ on VC0 with a WRITE header queued behind it.
    do_reset();
    src_q[0].push_back(mk(1, 0, TNOC_READ, 16'hB000));
    src_q[0].push_back(mk(0, 0, TNOC_READ, 16'hB001));
    src_q[0].push_back(mk(0, 0, TNOC_READ, 16'hB002));
    src_q[0].push_back(mk(0, 1, TNOC_READ, 16'hB003));
    src_q[0].push_back(mk(1, 1, TNOC_WRITE, 16'hC000));
    wait_drain("t2_drain");
    chk("t2_rd_count", rd_log.size(), 4);
    chk("t2_wr_count", wr_log.size(), 1);
    if (rd_log.size() == 4 && wr_log.size() == 1) begin
      for (int i = 0; i < 4; i++) chk("t2_rd_data", rd_log[i].data, 16'hB000 + 16'(i));
      chk("t2_wr_data", wr_log[0].data, 16'hC000);
      chk("t2_wr_after_tail", wr_log[0].cyc, rd_log[3].cyc + 1);
    end

    // Read-class 2-flit packets on both VCs: grants alternate per packet.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(mk(1, 0, TNOC_READ, 16'hD000 + 16'(2*i)));
      src_q[0].push_back(mk(0, 1, TNOC_READ, 16'hD001 + 16'(2*i)));
      src_q[1].push_back(mk(1, 0, TNOC_RESPONSE_WITH_DATA, 16'hE000 + 16'(2*i)));
      src_q[1].push_back(mk(0, 1, TNOC_RESPONSE_WITH_DATA, 16'hE001 + 16'(2*i)));
    end
    wait_drain("t3_drain");
    chk("t3_rd_count", rd_log.size(), 16);
    if (rd_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("t3_vc_order", rd_log[i].vc, (i / 2) % 2);
        chk("t3_data", rd_log[i].data,
            (((i / 2) % 2) ? 16'hE000 : 16'hD000) + 16'(2 * (i / 4) + (i % 2)));
      end
      chk("t3_gapless", rd_log[15].cyc - rd_log[0].cyc, 15);
    end

    // Write on VC0 and read on VC1 together: both ports load in the same cycle.
    do_reset();
    src_q[0].push_back(mk(1, 0, TNOC_WRITE, 16'h1100));
    src_q[0].push_back(mk(0, 1, TNOC_WRITE, 16'h1101));
    src_q[1].push_back(mk(1, 0, TNOC_READ, 16'h2200));
    src_q[1].push_back(mk(0, 1, TNOC_READ, 16'h2201));
    step(1);
    chk("t4_wr_valid", wr_if.valid, 1);
    chk("t4_rd_valid", rd_if.valid, 1);
    chk("t4_wr_vc", write_vc, 0);
    chk("t4_rd_vc", read_vc, 1);
    wait_drain("t4_drain");
    chk("t4_wr_count", wr_log.size(), 2);
    chk("t4_rd_count", rd_log.size(), 2);
    if (wr_log.size() == 2 && rd_log.size() == 2) chk("t4_same_cycle", wr_log[0].cyc, rd_log[0].cyc);

    // Read output stalled for 5 cycles mid-packet.
    do_reset();
    src_q[1].push_back(mk(1, 0, TNOC_READ, 16'hF010));
    src_q[1].push_back(mk(0, 0, TNOC_READ, 16'hF011));
    src_q[1].push_back(mk(0, 0, TNOC_READ, 16'hF012));
    src_q[1].push_back(mk(0, 1, TNOC_READ, 16'hF013));
    step(2);
    rd_if.ready = 1'b0;
    held_data = 16'hF011;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_hold_valid", rd_if.valid, 1);
      chk("t5_hold_data", rd_if.flit[0][FW-1:5], held_data);
      chk("t5_hold_vc", read_vc, 1);
      chk("t5_in_ready1", in_if.ready[1], 0);
    end
    rd_if.ready = 1'b1;
    wait_drain("t5_drain");
    chk("t5_rd_count", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_rd_data", rd_log[i].data, 16'hF010 + 16'(i));
      chk("t5_resume", rd_log[3].cyc - rd_log[1].cyc, 2);
    end

    // Asynchronous reset while the write port is locked to VC1.
    do_reset();
    src_q[1].push_back(mk(1, 0, TNOC_WRITE, 16'h3300));
    src_q[1].push_back(mk(0, 0, TNOC_WRITE, 16'h3301));
    src_q[1].push_back(mk(0, 0, TNOC_WRITE, 16'h3302));
    src_q[1].push_back(mk(0, 1, TNOC_WRITE, 16'h3303));
    step(2);
    chk("t6_pre_valid", wr_if.valid, 1);
    rst_n = 1'b0;
    for (int v = 0; v < CH; v++) src_q[v].delete();
    #1;
    chk("t6_wr_valid", wr_if.valid, 0);
    chk("t6_wr_flit", wr_if.flit[0], 0);
    chk("t6_wr_vc", write_vc, 0);
    chk("t6_rd_valid", rd_if.valid, 0);
    chk("t6_in_ready", in_if.ready, 0);
    step(2);
    rst_n = 1'b1;
    wr_log.delete();
    rd_log.delete();
    src_q[1].push_back(mk(1, 1, TNOC_WRITE, 16'h7777));
    step(1);
    chk("t6_new_valid", wr_if.valid, 1);
    chk("t6_new_vc", write_vc, 1);
    chk("t6_new_data", wr_if.flit[0][FW-1:5], 16'h7777);
    wait_drain("t6_drain");
    chk("t6_wr_count", wr_log.size(), 1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
